// File: rtl/capture_sequencer.sv
// Multi-record acquisition sequencer: arms the trigger generator, waits out the
// pre-trigger fill, accepts one trigger per record and frames the record window.
module capture_sequencer #(
   parameter int PRE_SAMPLES = 10,
   parameter int HOLDOFF     = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        arm,
   input  logic        abort,
   input  logic [15:0] record_len,
   input  logic [15:0] num_records,
   input  logic [31:0] timeout_cycles,
   input  logic        buf_ready,
   input  logic        trigger_start,
   output logic        capture_en,
   output logic        trigger_ready,
   output logic        rec_valid,
   output logic        rec_first,
   output logic        rec_last,
   output logic [15:0] record_idx,
   output logic        busy,
   output logic        done,
   output logic        timeout,
   output logic        aborted,
   output logic        cfg_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PREFILL,
      S_WAIT_TRIG,
      S_CAPTURE,
      S_HOLDOFF
   } state_t;

   localparam int FW = (PRE_SAMPLES > 1) ? $clog2(PRE_SAMPLES) : 1;
   localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
   localparam logic [FW-1:0] FILL_LAST = FW'(PRE_SAMPLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);

   state_t        state;
   logic [FW-1:0] fill_cnt;
   logic [HW-1:0] hold_cnt;
   logic [31:0]   wait_cnt;
   logic [31:0]   cap_cnt;
   logic [15:0]   rec_len_lat;
   logic [15:0]   num_rec_lat;
   logic [31:0]   timeout_lat;

   logic [31:0] win_len;
   logic        cap_last;
   logic        last_rec;
   logic        wait_expired;

   // Window covers the pre-trigger history plus the post-trigger record.
   assign win_len      = 32'(PRE_SAMPLES) + {16'd0, rec_len_lat};
   assign cap_last     = (cap_cnt == win_len - 32'd1);
   assign last_rec     = (record_idx == num_rec_lat - 16'd1);
   assign wait_expired = (timeout_lat != 32'd0) && (wait_cnt == timeout_lat - 32'd1);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         fill_cnt    <= '0;
         hold_cnt    <= '0;
         wait_cnt    <= '0;
         cap_cnt     <= '0;
         rec_len_lat <= '0;
         num_rec_lat <= '0;
         timeout_lat <= '0;
         record_idx  <= '0;
         done        <= 1'b0;
         timeout     <= 1'b0;
         aborted     <= 1'b0;
         cfg_err     <= 1'b0;
      end else begin
         done    <= 1'b0;
         timeout <= 1'b0;
         aborted <= 1'b0;
         cfg_err <= 1'b0;
         if (abort && state != S_IDLE) begin
            state   <= S_IDLE;
            aborted <= 1'b1;
         end else begin
            case (state)
               S_IDLE: begin
                  if (arm) begin
                     if (record_len == 16'd0 || num_records == 16'd0) begin
                        cfg_err <= 1'b1;
                     end else begin
                        rec_len_lat <= record_len;
                        num_rec_lat <= num_records;
                        timeout_lat <= timeout_cycles;
                        record_idx  <= '0;
                        fill_cnt    <= '0;
                        state       <= S_PREFILL;
                     end
                  end
               end
               S_PREFILL: begin
                  // Count saturates while the downstream buffer is not ready.
                  if (fill_cnt == FILL_LAST) begin
                     if (buf_ready) begin
                        wait_cnt <= '0;
                        state    <= S_WAIT_TRIG;
                     end
                  end else begin
                     fill_cnt <= fill_cnt + FW'(1);
                  end
               end
               S_WAIT_TRIG: begin
                  if (trigger_start) begin
                     cap_cnt <= '0;
                     state   <= S_CAPTURE;
                  end else if (wait_expired) begin
                     timeout <= 1'b1;
                     state   <= S_IDLE;
                  end else begin
                     wait_cnt <= wait_cnt + 32'd1;
                  end
               end
               S_CAPTURE: begin
                  if (cap_last) begin
                     if (HOLDOFF == 0) begin
                        if (last_rec) begin
                           done  <= 1'b1;
                           state <= S_IDLE;
                        end else begin
                           record_idx <= record_idx + 16'd1;
                           fill_cnt   <= '0;
                           state      <= S_PREFILL;
                        end
                     end else begin
                        hold_cnt <= '0;
                        state    <= S_HOLDOFF;
                     end
                  end else begin
                     cap_cnt <= cap_cnt + 32'd1;
                  end
               end
               S_HOLDOFF: begin
                  if (hold_cnt == HOLD_LAST) begin
                     if (last_rec) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                     end else begin
                        record_idx <= record_idx + 16'd1;
                        fill_cnt   <= '0;
                        state      <= S_PREFILL;
                     end
                  end else begin
                     hold_cnt <= hold_cnt + HW'(1);
                  end
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy          = (state != S_IDLE);
   assign capture_en    = (state == S_PREFILL) || (state == S_WAIT_TRIG) || (state == S_CAPTURE);
   assign trigger_ready = (state == S_WAIT_TRIG);
   assign rec_valid     = (state == S_CAPTURE);
   assign rec_first     = rec_valid && (cap_cnt == 32'd0);
   assign rec_last      = rec_valid && cap_last;

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: multi-record series, buffer stall,
// timeout, abort, config rejection and mid-record reset.
module tb_capture_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, arm, abort, buf_ready, trigger_start;
   logic [15:0] record_len, num_records;
   logic [31:0] timeout_cycles;
   logic        capture_en, trigger_ready, rec_valid, rec_first, rec_last;
   logic [15:0] record_idx;
   logic        busy, done, timeout, aborted, cfg_err;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int abort_cnt = 0;

   always #5 clk = ~clk;

   capture_sequencer #(.PRE_SAMPLES(10), .HOLDOFF(4)) dut (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort),
      .record_len(record_len), .num_records(num_records),
      .timeout_cycles(timeout_cycles), .buf_ready(buf_ready),
      .trigger_start(trigger_start), .capture_en(capture_en),
      .trigger_ready(trigger_ready), .rec_valid(rec_valid),
      .rec_first(rec_first), .rec_last(rec_last), .record_idx(record_idx),
      .busy(busy), .done(done), .timeout(timeout), .aborted(aborted),
      .cfg_err(cfg_err)
   );

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (aborted) abort_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench in cycle 1; config inputs are scrambled afterwards
   // to show the latched copy is what counts.
   task automatic do_arm(input int len, input int nrec, input int to);
      record_len     = 16'(len);
      num_records    = 16'(nrec);
      timeout_cycles = 32'(to);
      arm = 1'b1;
      tick();
      arm            = 1'b0;
      record_len     = 16'h00ff;
      num_records    = 16'h0000;
      timeout_cycles = 32'd3;
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (!trigger_ready && n < 500) begin
         tick();
         n++;
      end
   endtask

   task automatic pulse_trig();
      trigger_start = 1'b1;
      tick();
      trigger_start = 1'b0;
   endtask

   // Starts in the first PREFILL cycle, ends in the first cycle after the window.
   task automatic run_record(input int exp_len, input int exp_idx);
      int n, last_at;
      wait_ready(n);
      chk("ready_lat", n, 10);
      repeat (5) tick();
      pulse_trig();
      chk("rec_first", {29'd0, rec_valid, rec_first, trigger_ready}, 32'b110);
      chk("rec_idx", {16'd0, record_idx}, exp_idx);
      n = 0;
      last_at = 0;
      while (rec_valid && n < 5000) begin
         n++;
         if (rec_last) last_at = n;
         tick();
      end
      chk("win_len", n, exp_len);
      chk("last_pos", last_at, exp_len);
   endtask

   function automatic logic [9:0] outs();
      return {capture_en, trigger_ready, rec_valid, rec_first, rec_last,
              busy, done, timeout, aborted, cfg_err};
   endfunction

   initial begin
      int n, d0, a0;
      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; buf_ready = 1'b1; trigger_start = 1'b0;
      record_len = '0; num_records = '0; timeout_cycles = '0;
      repeat (2) tick();
      chk("reset_outs", {22'd0, outs()}, 0);
      chk("reset_idx", {16'd0, record_idx}, 0);
      rst_n = 1'b1;
      tick();

      // three-record series
      d0 = done_cnt;
      do_arm(100, 3, 0);
      chk("arm_busy", {30'd0, busy, capture_en}, 2'b11);
      chk("arm_tr", {31'd0, trigger_ready}, 0);
      for (int r = 0; r < 3; r++) begin
         run_record(110, r);
         chk("hold_en", {30'd0, capture_en, busy}, 2'b01);
         repeat (4) tick();
         if (r < 2) begin
            chk("prefill_again", {29'd0, capture_en, trigger_ready, busy}, 3'b101);
            chk("idx_inc", {16'd0, record_idx}, r + 1);
         end else begin
            chk("series_done", {30'd0, done, busy}, 2'b10);
            chk("final_idx", {16'd0, record_idx}, 2);
         end
      end
      tick();
      chk("done_count", done_cnt - d0, 1);

      // buffer stall during PREFILL, stray trigger ignored
      buf_ready = 1'b0;
      do_arm(8, 1, 0);
      repeat (2) tick();
      pulse_trig();
      chk("stray_trig", {31'd0, rec_valid}, 0);
      repeat (16) tick();
      chk("stall_tr", {30'd0, trigger_ready, capture_en}, 2'b01);
      buf_ready = 1'b1;
      tick();
      chk("stall_release", {31'd0, trigger_ready}, 1);
      repeat (5) tick();
      pulse_trig();
      n = 0;
      while (rec_valid && n < 500) begin n++; tick(); end
      chk("stall_win", n, 18);
      repeat (4) tick();
      chk("stall_done", {31'd0, done}, 1);
      tick();

      // timeout after 50 waiting clocks
      do_arm(8, 1, 50);
      wait_ready(n);
      chk("to_ready_lat", n, 10);
      repeat (49) tick();
      chk("to_last_wait", {29'd0, trigger_ready, busy, timeout}, 3'b110);
      tick();
      chk("to_pulse", {29'd0, trigger_ready, busy, timeout}, 3'b001);
      tick();
      chk("to_clear", {31'd0, timeout}, 0);

      // trigger on the final waiting cycle wins over timeout
      a0 = abort_cnt;
      do_arm(8, 1, 50);
      wait_ready(n);
      repeat (49) tick();
      pulse_trig();
      chk("to_trig_wins", {29'd0, rec_valid, timeout, busy}, 3'b101);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_cap", {29'd0, aborted, busy, rec_valid}, 3'b100);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_idle", {30'd0, aborted, busy}, 0);
      chk("abort_count", abort_cnt - a0, 1);

      // abort on the 37th window clock of record 1
      d0 = done_cnt;
      a0 = abort_cnt;
      do_arm(100, 3, 0);
      run_record(110, 0);
      repeat (4) tick();
      wait_ready(n);
      repeat (5) tick();
      pulse_trig();
      repeat (36) tick();
      chk("pre_abort", {15'd0, rec_valid, record_idx}, {15'd0, 1'b1, 16'd1});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("mid_abort", {22'd0, outs()}, 10'b0000000010);
      chk("abort_idx", {16'd0, record_idx}, 1);
      tick();
      chk("abort_once", abort_cnt - a0, 1);
      chk("abort_no_done", done_cnt - d0, 0);

      // config rejection
      do_arm(100, 0, 0);
      chk("cfg_nrec0", {30'd0, cfg_err, busy}, 2'b10);
      tick();
      do_arm(0, 3, 0);
      chk("cfg_len0", {30'd0, cfg_err, busy}, 2'b10);
      tick();
      chk("cfg_clear", {31'd0, cfg_err}, 0);

      // arm together with abort while idle is accepted
      record_len = 16'd4; num_records = 16'd1; timeout_cycles = 32'd0;
      arm = 1'b1; abort = 1'b1;
      tick();
      arm = 1'b0; abort = 1'b0;
      chk("arm_abort_idle", {30'd0, busy, aborted}, 2'b10);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();

      // arm during CAPTURE is ignored
      d0 = done_cnt;
      do_arm(4, 1, 0);
      wait_ready(n);
      repeat (5) tick();
      pulse_trig();
      record_len = 16'd50; num_records = 16'd5; arm = 1'b1;
      tick();
      arm = 1'b0;
      n = 1;
      while (rec_valid && n < 500) begin n++; tick(); end
      chk("rearm_win", n, 14);
      repeat (4) tick();
      chk("rearm_done", {15'd0, done, record_idx}, {15'd0, 1'b1, 16'd0});
      tick();
      chk("rearm_done_cnt", done_cnt - d0, 1);

      // reset mid-CAPTURE of record 1, then a fresh series
      do_arm(100, 2, 0);
      run_record(110, 0);
      repeat (4) tick();
      wait_ready(n);
      repeat (5) tick();
      pulse_trig();
      repeat (5) tick();
      rst_n = 1'b0;
      tick();
      chk("rst_outs", {22'd0, outs()}, 0);
      chk("rst_idx", {16'd0, record_idx}, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_idle", {31'd0, busy}, 0);
      do_arm(4, 1, 0);
      run_record(14, 0);
      repeat (4) tick();
      chk("fresh_done", {30'd0, done, busy}, 2'b10);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog expired");
      $fatal(1, "bench did not finish");
   end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences the two-sample-per-clock trigger datapath through a multi-record acquisition: arms the trigger generator, waits out the pre-trigger fill, accepts one trigger per record, frames the record window for the downstream buffer, and enforces hold-off between records. Sits between the host control registers and the trigger generator / pre-trigger FIFO. It drives that generator's `Capture_En` and `Trigger_Ready` inputs and consumes its `trigger_start` output.

## Interface
- PRE_SAMPLES, 10: pre-trigger depth in clocks (2 samples/clock); min 2; must equal the trigger generator's BEFORE_TRIGGER.
- HOLDOFF, 4: dead clocks after each record before re-arming; 0 allowed.
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- arm  in  1  1-cycle pulse; starts an acquisition series
- abort  in  1  level/pulse; terminates the series immediately
- record_len  in  16  post-trigger record length in clocks; latched at accepted arm
- num_records  in  16  records per series; latched at accepted arm
- timeout_cycles  in  32  max clocks waiting for a trigger; 0 = no timeout; latched at arm
- buf_ready  in  1  downstream buffer can accept a full record
- trigger_start  in  1  1-cycle trigger pulse from the trigger generator
- capture_en  out  1  to generator `Capture_En`
- trigger_ready  out  1  to generator `Trigger_Ready`
- rec_valid  out  1  record window; read/write enable for FIFO and buffer
- rec_first  out  1  first clock of rec_valid
- rec_last  out  1  last clock of rec_valid
- record_idx  out  16  index of current or most recent record, 0-based
- busy  out  1  state != IDLE
- done  out  1  1-cycle pulse; series completed normally
- timeout  out  1  1-cycle pulse; series ended by trigger timeout
- aborted  out  1  1-cycle pulse; series ended by abort
- cfg_err  out  1  1-cycle pulse; arm rejected because record_len or num_records is 0

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, CAPTURE, HOLDOFF.
- IDLE:
  - All enables are 0.
  - arm with both lengths nonzero latches the config, clears record_idx and goes to PREFILL.
  - arm with either length zero pulses cfg_err and stays in IDLE.
- PREFILL:
  - capture_en=1 and trigger_ready=0.
  - The fill counter counts PRE_SAMPLES clocks.
  - When the count is complete and buf_ready=1, go to WAIT_TRIG. If buf_ready=0, hold with the count saturated.
- WAIT_TRIG:
  - capture_en=1 and trigger_ready=1.
  - The wait counter starts at 0 on entry and increments every clock.
  - trigger_start=1 goes to CAPTURE.
  - If timeout_cycles≠0 and the counter reaches timeout_cycles-1 without a trigger, go to IDLE and pulse timeout.
  - If trigger_start and the timeout condition occur on the same cycle, the trigger wins.
- CAPTURE:
  - capture_en=1 and trigger_ready=0.
  - rec_valid is high for exactly PRE_SAMPLES+record_len clocks (32-bit sum, no overflow).
  - At the last clock, go to HOLDOFF, or straight to the end-of-record decision if HOLDOFF=0.
- HOLDOFF:
  - All enables are 0 for HOLDOFF clocks.
  - End-of-record decision: if record_idx==num_records-1, go to IDLE and pulse done. Otherwise increment record_idx and go to PREFILL.
- trigger_start outside WAIT_TRIG is ignored. arm while busy is ignored. Input config changes while busy have no effect.
- abort:
  - Highest priority in any non-IDLE state.
  - The next state is IDLE and aborted pulses.
  - rec_valid, capture_en and trigger_ready are 0 from the next cycle.
  - abort while IDLE does nothing.
  - abort and arm in the same cycle while IDLE: arm is accepted.
- rst_n=0: state IDLE, all counters 0, record_idx 0, and every output 0 at the next edge. This applies mid-record as well.

## Timing
- Outputs capture_en, trigger_ready, rec_valid, rec_first, rec_last and busy are decoded from the registered state and counters. The pulses done, timeout, aborted and cfg_err are registered.
- Take edge 0 as the edge that samples arm=1:
  - busy=1 and capture_en=1 from cycle 1.
  - trigger_ready=1 from cycle 1+PRE_SAMPLES, provided buf_ready=1.
- Take edge t as the edge that samples trigger_start=1:
  - trigger_ready=0 from t+1.
  - rec_valid=1 and rec_first=1 in cycle t+1.
  - rec_last=1 and the final rec_valid in cycle t+PRE_SAMPLES+record_len.
- The next PREFILL starts at t+PRE_SAMPLES+record_len+HOLDOFF+1.
- done pulses in the first IDLE cycle, which is the same cycle busy falls. timeout and aborted behave the same way.
- For PRE_SAMPLES+record_len=1, rec_first and rec_last coincide.

## Test plan
- PRE_SAMPLES=10, HOLDOFF=4, arm with record_len=100, num_records=3, and a trigger 5 clocks after each trigger_ready rise -> three rec_valid windows of 110 clocks each, record_idx 0,1,2, one done pulse, busy low after the third hold-off.
- buf_ready=0 during the first PREFILL for 20 clocks -> trigger_ready rises exactly 1 clock after buf_ready rises; a trigger_start during PREFILL produces no rec_valid.
- timeout_cycles=50 with no trigger -> timeout pulse 50 clocks after WAIT_TRIG entry, busy=0. Repeat with trigger_start in that same final cycle -> CAPTURE, no timeout pulse.
- abort asserted at the 37th rec_valid clock of record 1 -> rec_valid=0 the next cycle, one aborted pulse, no done pulse, record_idx=1 held.
- arm with num_records=0 -> cfg_err pulse, busy stays 0. arm during CAPTURE -> ignored, record count unchanged.
- rst_n=0 for 1 clock mid-CAPTURE -> all outputs 0 at the next edge; a fresh arm afterwards runs a normal series from record 0.
